// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory arbiter: FSM states,
// requester indices and memory geometry.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam int NUM_REQ    = 3;
    localparam int REQ_LD     = 0;
    localparam int REQ_DM     = 1;
    localparam int REQ_IF     = 2;

    localparam int MEM_DEPTH  = 1024;
    localparam int MEM_AW_DEF = 10;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational fixed-priority picker (ld > dm > if) with an override that
// lets a starved fetch beat dm once the data streak is full.
module mips_arb_pick
    import mips_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] excl_i,
    input  logic               streak_full_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [NUM_REQ-1:0] elig;
    assign elig = req_i & ~excl_i;

    always_comb begin
        gnt_o = '0;
        if (elig[REQ_LD])
            gnt_o[REQ_LD] = 1'b1;
        else if (elig[REQ_IF] && streak_full_i)
            gnt_o[REQ_IF] = 1'b1;
        else if (elig[REQ_DM])
            gnt_o[REQ_DM] = 1'b1;
        else if (elig[REQ_IF])
            gnt_o[REQ_IF] = 1'b1;
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Three-port arbiter (loader, data, fetch) onto one single-port synchronous RAM.
// IDLE -> ISSUE -> RESP, with back-to-back accesses re-arbitrated in RESP.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int STREAK_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic              ld_err,
    output logic [31:0]       ld_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic [31:0]       dm_rdata,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STREAK_MAX + 1);

    state_e             state_q;
    logic [NUM_REQ-1:0] win_q, ack_q;
    logic               we_q, err_q;
    logic [SW-1:0]      streak_q, streak_d;
    logic               mem_en_q, mem_we_q;
    logic [MEM_AW-1:0]  mem_addr_q;
    logic [31:0]        mem_wdata_q;

    logic [NUM_REQ-1:0] req_vec, excl, gnt;
    logic               streak_full, arb_en, take, if_pend;
    logic [31:0]        sel_addr, sel_wdata;
    logic               sel_we, sel_oor, rd_ok;

    assign req_vec = {if_req, dm_req, ld_req};
    // The RESP winner still holds its req for the access being acked, so it
    // cannot win the slot that immediately follows.
    assign excl        = (state_q == ST_RESP) ? win_q : '0;
    assign streak_full = (streak_q == SW'(STREAK_MAX));
    assign arb_en      = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign take        = arb_en && (|gnt);
    assign if_pend     = req_vec[REQ_IF] & ~excl[REQ_IF];

    mips_arb_pick u_pick (
        .req_i         (req_vec),
        .excl_i        (excl),
        .streak_full_i (streak_full),
        .gnt_o         (gnt)
    );

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        if (gnt[REQ_LD]) begin
            sel_addr  = ld_addr;
            sel_we    = ld_we;
            sel_wdata = ld_wdata;
        end else if (gnt[REQ_DM]) begin
            sel_addr  = dm_addr;
            sel_we    = dm_we;
            sel_wdata = dm_wdata;
        end else if (gnt[REQ_IF]) begin
            sel_addr  = if_addr;
        end
    end

    assign sel_oor = |sel_addr[31:MEM_AW];

    always_comb begin
        streak_d = streak_q;
        if (take && gnt[REQ_DM])
            streak_d = !if_pend ? '0 : (streak_full ? streak_q : streak_q + 1'b1);
        else if (take && gnt[REQ_IF])
            streak_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            ack_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= '0;
            streak_q    <= streak_d;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (take) begin
                        state_q     <= ST_ISSUE;
                        win_q       <= gnt;
                        we_q        <= sel_we;
                        err_q       <= sel_oor;
                        mem_en_q    <= ~sel_oor;
                        mem_we_q    <= sel_we & ~sel_oor;
                        mem_addr_q  <= sel_addr[MEM_AW-1:0];
                        mem_wdata_q <= sel_wdata;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_RESP;
                    ack_q   <= win_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_ok     = ~we_q & ~err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);

    assign ld_ack   = ack_q[REQ_LD];
    assign dm_ack   = ack_q[REQ_DM];
    assign if_ack   = ack_q[REQ_IF];
    assign ld_err   = ack_q[REQ_LD] & err_q;
    assign dm_err   = ack_q[REQ_DM] & err_q;
    assign if_err   = ack_q[REQ_IF] & err_q;
    assign ld_rdata = (ack_q[REQ_LD] && rd_ok) ? mem_rdata : '0;
    assign dm_rdata = (ack_q[REQ_DM] && rd_ok) ? mem_rdata : '0;
    assign if_rdata = (ack_q[REQ_IF] && rd_ok) ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: behavioural RAM, ack log, hand-derived
// grant orders and data.
module tb_mips_mem_arbiter;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_req, ld_we, dm_req, dm_we, if_req;
    logic [31:0] ld_addr, ld_wdata, dm_addr, dm_wdata, if_addr;
    logic        ld_ack, ld_err, dm_ack, dm_err, if_ack, if_err;
    logic [31:0] ld_rdata, dm_rdata, if_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:MEM_DEPTH-1];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, multi_ack = 0, stray_rd = 0, en_cnt = 0;
    int log_id[$], log_cyc[$];
    logic [31:0] log_dat[$], log_err[$];

    always #5 clk = ~clk;

    mips_mem_arbiter #(.MEM_AW(10), .STREAK_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_err(ld_err), .ld_rdata(ld_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(ld_ack) + int'(dm_ack) + int'(if_ack) > 1) multi_ack++;
            if ((!ld_ack && ld_rdata != 0) || (!dm_ack && dm_rdata != 0) ||
                (!if_ack && if_rdata != 0)) stray_rd++;
            if (mem_en) en_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    // Runs n cycles, logging every ack; without hold the acked req is dropped.
    task automatic run(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ld_ack) begin
                log_id.push_back(REQ_LD); log_dat.push_back(ld_rdata);
                log_err.push_back(32'(ld_err)); log_cyc.push_back(cyc);
                if (!hold) ld_req = 1'b0;
            end
            if (dm_ack) begin
                log_id.push_back(REQ_DM); log_dat.push_back(dm_rdata);
                log_err.push_back(32'(dm_err)); log_cyc.push_back(cyc);
                if (!hold) dm_req = 1'b0;
            end
            if (if_ack) begin
                log_id.push_back(REQ_IF); log_dat.push_back(if_rdata);
                log_err.push_back(32'(if_err)); log_cyc.push_back(cyc);
                if (!hold) if_req = 1'b0;
            end
        end
    endtask

    task automatic clr_log();
        log_id.delete(); log_dat.delete(); log_err.delete(); log_cyc.delete();
    endtask

    task automatic chk_order(input string tag, input int want[$]);
        chk({tag, "_n"}, 32'(log_id.size()), 32'(want.size()));
        for (int k = 0; k < want.size(); k++)
            chk($sformatf("%s_%0d", tag, k),
                (k < log_id.size()) ? 32'(log_id[k]) : 32'hFFFF_FFFF, 32'(want[k]));
    endtask

    task automatic drop_all();
        ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0; ld_we = 1'b0; dm_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) ram[i] = 32'h1000_0000 + 32'(i);
        ram[5]     = 32'hDEAD_BEEF;
        ram[0]     = 32'hA5A5_0000;
        ram[7]     = 32'h7777_0000;
        ram[10'h3FF] = 32'hFFFF_0000;
        mem_rdata  = '0;
        rst_n      = 1'b0;
        drop_all();
        ld_addr = '0; ld_wdata = '0; dm_addr = '0; dm_wdata = '0; if_addr = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack_err", {26'd0, ld_ack, dm_ack, if_ack, ld_err, dm_err, if_err}, 0);
        chk("rst_rdata", ld_rdata | dm_rdata | if_rdata, 0);
        rst_n = 1'b1;

        // Single dm read: mem_en in cycle 1, ack with data in cycle 2
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h5;
        @(negedge clk);
        chk("rd_c1_mem_en", 32'(mem_en), 1);
        chk("rd_c1_mem_addr", 32'(mem_addr), 32'h5);
        chk("rd_c1_ack", 32'(dm_ack), 0);
        chk("rd_c1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("rd_c2_mem_en", 32'(mem_en), 0);
        chk("rd_c2_ack", 32'(dm_ack), 1);
        chk("rd_c2_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_req = 1'b0;
        @(negedge clk);
        chk("rd_c3_ack", 32'(dm_ack), 0);
        chk("rd_c3_busy", 32'(busy), 0);

        // All three at once: ld write, then dm reads it back, then fetch
        clr_log();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h3FF; ld_wdata = 32'h1234_5678;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3FF;
        if_req = 1'b1; if_addr = 32'h0;
        run(8, 1'b0);
        chk_order("tri_order", '{REQ_LD, REQ_DM, REQ_IF});
        if (log_id.size() == 3) begin
            chk("tri_wr_rdata", log_dat[0], 32'h0);
            chk("tri_dm_rdata", log_dat[1], 32'h1234_5678);
            chk("tri_if_rdata", log_dat[2], 32'hA5A5_0000);
            chk("tri_gap", 32'(log_cyc[2] - log_cyc[0]), 32'd4);
        end
        drop_all();

        // Out-of-range fetch: err, zero data, no RAM enable
        clr_log(); en_cnt = 0;
        if_req = 1'b1; if_addr = 32'h400;
        run(5, 1'b0);
        chk_order("oor_order", '{REQ_IF});
        if (log_id.size() == 1) begin
            chk("oor_err", log_err[0], 32'h1);
            chk("oor_rdata", log_dat[0], 32'h0);
        end
        chk("oor_mem_en_cnt", 32'(en_cnt), 0);
        drop_all();

        // Reset during ISSUE of a dm write aborts it
        clr_log();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h7; dm_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("abort_issue_en", 32'(mem_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_en_drop", 32'(mem_en), 0);
        chk("abort_we_drop", 32'(mem_we), 0);
        chk("abort_busy", 32'(busy), 0);
        drop_all();
        @(negedge clk); rst_n = 1'b1;
        run(6, 1'b0);
        chk("abort_no_ack", 32'(log_id.size()), 0);
        chk("abort_ram7", ram[7], 32'h7777_0000);

        // Winner re-requests at once: the waiting fetch goes next, then alternate
        clr_log();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h3;
        run(11, 1'b1);
        chk_order("alt_order", '{REQ_DM, REQ_IF, REQ_DM, REQ_IF, REQ_DM, REQ_IF});
        if (log_id.size() == 6) begin
            chk("alt_dm_rdata", log_dat[0], 32'h1000_0002);
            chk("alt_if_rdata", log_dat[1], 32'h1000_0003);
            chk("alt_if_gap", 32'(log_cyc[3] - log_cyc[1]), 32'd4);
        end
        drop_all();
        run(4, 1'b0);
        chk("alt_drain_busy", 32'(busy), 0);

        // All held: dm streak of 3 while fetch waits, then fetch wins over dm
        do_reset();
        clr_log();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2;
        if_req = 1'b1; if_addr = 32'h3;
        run(25, 1'b1);
        chk_order("stk_order", '{REQ_LD, REQ_DM, REQ_LD, REQ_DM, REQ_LD, REQ_DM,
                                 REQ_LD, REQ_IF, REQ_LD, REQ_DM, REQ_LD, REQ_DM});
        if (log_id.size() == 12) begin
            chk("stk_span", 32'(log_cyc[11] - log_cyc[0]), 32'd22);
            chk("stk_if_rdata", log_dat[7], 32'h1000_0003);
        end
        drop_all();
        run(4, 1'b0);

        chk("one_ack_per_cycle", 32'(multi_ack), 0);
        chk("idle_rdata_zero", 32'(stray_rd), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
